// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants: production and simulation timing values plus
// the counter-width helper used to size the debounce and hold counters.
package stopwatch_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 1000000;  // 10 ms at 100 MHz
  localparam int LONG_CYCLES_DEF     = 2000000;
  localparam int DEBOUNCE_CYCLES_SIM = 4;
  localparam int LONG_CYCLES_SIM     = 10;

  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(DEBOUNCE_CYCLES_DEF);

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchroniser, counter debounce of the synced level,
// and a combinational press strobe asserted on the edge the level rises.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synced input agrees with the level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press   = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == TERM) begin
        level_d = sync2_q;
        press   = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/btn_pulse_gen.sv
// Stopwatch button front end: debounced trig/split pulses, never coincident.
// Optional long-press detection on split is enabled by defining BTN_LONG_PRESS_EN.
module btn_pulse_gen
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_trig_raw,
  input  logic btn_split_raw,
  output logic trig,
  output logic split,
  output logic trig_level,
  output logic split_level,
  output logic long_clear
);

  logic trig_press, split_press;
  logic trig_lvl, split_lvl;
  logic trig_q, trig_d;
  logic split_q, split_d;
  logic pending_q, pending_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_trig_db (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_trig_raw),
    .level (trig_lvl),
    .press (trig_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_split_db (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_split_raw),
    .level (split_lvl),
    .press (split_press)
  );

  // Trig wins a collision; a deferred split waits in pending and merges with
  // any further split press until it can be issued.
  always_comb begin
    trig_d    = 1'b0;
    split_d   = 1'b0;
    pending_d = 1'b0;
    if (trig_press) begin
      trig_d    = 1'b1;
      pending_d = split_press | pending_q;
    end else begin
      split_d = split_press | pending_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q    <= 1'b0;
      split_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      trig_q    <= trig_d;
      split_q   <= split_d;
      pending_q <= pending_d;
    end
  end

  assign trig        = trig_q;
  assign split       = split_q;
  assign trig_level  = trig_lvl;
  assign split_level = split_lvl;

`ifdef BTN_LONG_PRESS_EN
  localparam int               HOLD_W   = cnt_width(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;

  // Saturating at HOLD_MAX limits each hold to a single long_clear.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!split_lvl) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + 1'b1;
      long_d = (hold_q == HOLD_MAX - 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_clear = long_q;
`else
  logic unused_long_cfg;
  assign unused_long_cfg = (LONG_CYCLES > 0);
  assign long_clear      = 1'b0;
`endif

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Scoreboard bench for btn_pulse_gen: expected pulse cycles are queued when
// stimulus is applied and matched against observed pulses. Long-press expectations follow BTN_LONG_PRESS_EN.
module tb_btn_pulse_gen;
  import stopwatch_pkg::*;

  localparam int DEB   = DEBOUNCE_CYCLES_SIM;
  localparam int LONGC = LONG_CYCLES_SIM;
  // raw changed after edge n -> sampled at n+1 -> synced at n+2 -> level flips at n+2+DEB
  localparam int LAT   = DEB + 2;

  logic clk = 1'b0;
  logic reset, btn_trig_raw, btn_split_raw;
  logic trig, split, trig_level, split_level, long_clear;

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;
  int exp_trig[$];
  int exp_split[$];
  int exp_long[$];

  always #5 clk = ~clk;

  btn_pulse_gen #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (cnt_width(DEB)),
    .LONG_CYCLES     (LONGC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_trig_raw  (btn_trig_raw),
    .btn_split_raw (btn_split_raw),
    .trig          (trig),
    .split         (split),
    .trig_level    (trig_level),
    .split_level   (split_level),
    .long_clear    (long_clear)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  task automatic drain(input string name);
    tick(12);
    chk({name, "_trig_missing"},  exp_trig.size(),  0);
    chk({name, "_split_missing"}, exp_split.size(), 0);
    chk({name, "_long_missing"},  exp_long.size(),  0);
    exp_trig.delete();
    exp_split.delete();
    exp_long.delete();
  endtask

  // Output monitor: every observed pulse must match the oldest expectation.
  always @(negedge clk) begin
    int e;
    if (trig) begin
      if (exp_trig.size() > 0) begin
        e = exp_trig.pop_front();
        chk("trig_cycle", cyc, e);
      end else chk("trig_extra", trig, 0);
    end
    if (split) begin
      if (exp_split.size() > 0) begin
        e = exp_split.pop_front();
        chk("split_cycle", cyc, e);
      end else chk("split_extra", split, 0);
    end
    if (long_clear) begin
      if (exp_long.size() > 0) begin
        e = exp_long.pop_front();
        chk("long_cycle", cyc, e);
      end else chk("long_extra", long_clear, 0);
    end
    if (trig && split) chk("both_high", trig & split, 0);
  end

  initial begin
    int n;
    int pat[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

    // Reset with both buttons held
    reset = 1'b1; btn_trig_raw = 1'b1; btn_split_raw = 1'b1;
    tick(3);
    chk("rst_trig",        trig,        0);
    chk("rst_split",       split,       0);
    chk("rst_trig_level",  trig_level,  0);
    chk("rst_split_level", split_level, 0);
    chk("rst_long",        long_clear,  0);
    reset = 1'b0;
    n = cyc;
    exp_trig.push_back(n + LAT);
    exp_split.push_back(n + LAT + 1);
    tick(LAT + 4);
    btn_trig_raw = 1'b0; btn_split_raw = 1'b0;
    drain("rst");
    chk("rst_levels_low", {30'd0, trig_level, split_level}, 0);

    // Clean trig press, 20 cycles
    n = cyc;
    btn_trig_raw = 1'b1;
    exp_trig.push_back(n + LAT);
    tick(LAT - 1);
    chk("press_lvl_before", trig_level, 0);
    tick();
    chk("press_lvl_rise", trig_level, 1);
    tick(20 - LAT);
    btn_trig_raw = 1'b0;
    tick(LAT - 1);
    chk("release_lvl_before", trig_level, 1);
    tick();
    chk("release_lvl_fall", trig_level, 0);
    drain("press");

    // Bouncing split press
    n = cyc;
    exp_split.push_back(n + 5 + LAT);
    for (int i = 0; i < 9; i++) begin
      btn_split_raw = pat[i][0];
      tick();
    end
    btn_split_raw = 1'b0;
    tick();
    chk("bounce_lvl_before", split_level, 0);
    tick();
    chk("bounce_lvl_rise", split_level, 1);
    drain("bounce");

    // Short glitch on trig
    btn_trig_raw = 1'b1;
    tick(3);
    btn_trig_raw = 1'b0;
    tick(3);
    chk("glitch_lvl_mid", trig_level, 0);
    tick(6);
    chk("glitch_lvl_end", trig_level, 0);
    drain("glitch");

    // Simultaneous press
    n = cyc;
    btn_trig_raw = 1'b1; btn_split_raw = 1'b1;
    exp_trig.push_back(n + LAT);
    exp_split.push_back(n + LAT + 1);
    tick(15);
    btn_trig_raw = 1'b0; btn_split_raw = 1'b0;
    drain("simul");

    // Reset mid-count restarts the debounce
    btn_trig_raw = 1'b1;
    tick(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = cyc;
    exp_trig.push_back(n + LAT);
    tick(10);
    btn_trig_raw = 1'b0;
    drain("midrst");

    // Long split hold
    n = cyc;
    btn_split_raw = 1'b1;
    exp_split.push_back(n + LAT);
`ifdef BTN_LONG_PRESS_EN
    exp_long.push_back(n + LAT + LONGC);
`endif
    tick(30);
    btn_split_raw = 1'b0;
    drain("long30");

    // Short split hold: no long_clear
    n = cyc;
    btn_split_raw = 1'b1;
    exp_split.push_back(n + LAT);
    tick(8);
    btn_split_raw = 1'b0;
    drain("long8");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
